// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: FSM state encoding and default memory geometry.
// The instruction memory imports the same defaults so the two depths agree.
package prog_loader_pkg;

  localparam int unsigned PL_DEPTH  = 256;
  localparam int unsigned PL_ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader: streams instruction words into the instruction
// memory, holds the core in reset while loading, and flags oversized programs.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = PL_DEPTH,
  parameter int unsigned ADDR_W = PL_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ovf_q, ovf_d;
  logic                accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

  // in_ready comes from the state register alone, so accept never loops back
  // through the upstream producer's valid logic.
  assign accept = (state_q == ST_LOAD) && in_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end

      ST_ERR: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = in_data;
          ptr_d   = ptr_q + ADDR_W'(1);
          cnt_d   = cnt_q + (ADDR_W + 1)'(1);
          // A last word at the final slot is a legal full-depth program.
          if (in_last) begin
            state_d = ST_FLUSH;
          end else if (ptr_q == LAST_PTR) begin
            state_d = ST_ERR;
            ovf_d   = 1'b1;
          end
        end
      end

      ST_FLUSH: state_d = ST_RUN;

      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign cpu_hold   = (state_q != ST_RUN);
  assign done       = (state_q == ST_RUN);
  assign overflow   = ovf_q;
  assign word_count = cnt_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (DEPTH=8) with a per-cycle reference model
// and literal expectations on the memory image and key timing points.
module tb_prog_loader;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int errors = 0;

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: loading / flushing / running / errored phases of a load.
  bit          m_load, m_flush, m_run, m_err, m_ovf, m_we;
  int          m_ptr, m_cnt;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0] m_data;
  bit          mdl_on = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_load <= 0; m_flush <= 0; m_run <= 0; m_err <= 0; m_ovf <= 0; m_we <= 0;
      m_ptr <= 0; m_cnt <= 0; m_addr <= '0; m_data <= '0;
    end else begin
      m_we <= m_load && in_valid;
      if (m_load && in_valid) begin
        m_addr <= m_ptr[ADDR_W-1:0];
        m_data <= in_data;
        m_cnt  <= m_cnt + 1;
        m_ptr  <= (m_ptr + 1) % DEPTH;
        if (in_last) begin
          m_load <= 0; m_flush <= 1;
        end else if (m_ptr == DEPTH - 1) begin
          m_load <= 0; m_err <= 1; m_ovf <= 1;
        end
      end else if (m_flush) begin
        m_flush <= 0; m_run <= 1;
      end else if (!m_load && start) begin
        m_load <= 1; m_run <= 0; m_err <= 0; m_ovf <= 0; m_ptr <= 0; m_cnt <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("in_ready", 32'(in_ready), 32'(m_load));
      chk("cpu_hold", 32'(cpu_hold), 32'(!m_run));
      chk("done", 32'(done), 32'(m_run));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("word_count", 32'(word_count), 32'(m_cnt));
      chk("imem_we", 32'(imem_we), 32'(m_we));
      if (m_we) begin
        chk("imem_addr", 32'(imem_addr), 32'(m_addr));
        chk("imem_wdata", imem_wdata, m_data);
      end
    end
  end

  // Observed memory image and write log.
  logic [31:0] sim_mem [DEPTH];
  int          wcnt [DEPTH];
  int          wr_total = 0;
  int          cyc = 0;
  int          addr_log[$];
  int          cyc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      sim_mem[imem_addr] = imem_wdata;
      wcnt[imem_addr]    = wcnt[imem_addr] + 1;
      wr_total           = wr_total + 1;
      addr_log.push_back(int'(imem_addr));
      cyc_log.push_back(cyc);
    end
  end

  task automatic clr_log();
    for (int unsigned i = 0; i < DEPTH; i++) wcnt[i] = 0;
    wr_total = 0;
    addr_log.delete();
    cyc_log.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present one beat and return just after the edge that accepts it.
  task automatic beat(input logic [31:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL beat_timeout actual=no_accept required=accept data=%h", d);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  logic [31:0] prog4 [4] = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin sim_mem[i] = '0; wcnt[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    rst = 1'b1;
    mdl_on = 1'b1;
    idle(2);
    chk("idle_ready", 32'(in_ready), 32'd0);

    // start and in_valid together in IDLE: only start acts
    @(negedge clk); start = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
    #1 chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_no_we", 32'(imem_we), 32'd0);

    // basic 4-word load
    clr_log();
    for (int i = 0; i < 4; i++) beat(prog4[i], i == 3);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("flush_we", 32'(imem_we), 32'd1);
    chk("flush_addr", 32'(imem_addr), 32'd3);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    chk("run_done", 32'(done), 32'd1);
    chk("run_hold", 32'(cpu_hold), 32'd0);
    chk("run_we", 32'(imem_we), 32'd0);
    chk("basic_wc", 32'(word_count), 32'd4);
    chk("basic_writes", 32'(wr_total), 32'd4);
    if (cyc_log.size() == 4) chk("basic_consec", 32'(cyc_log[3] - cyc_log[0]), 32'd3);
    else chk("basic_nlog", 32'(cyc_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_mem", sim_mem[i], prog4[i]);
      chk("basic_once", 32'(wcnt[i]), 32'd1);
    end

    // reload from RUN with bubbles 1,0,0,1,1
    clr_log();
    pulse_start();
    #1;
    chk("reload_hold", 32'(cpu_hold), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_wc", 32'(word_count), 32'd0);
    beat(32'hA0000000, 1'b0);
    idle(2);
    beat(32'hA0000001, 1'b0);
    beat(32'hA0000002, 1'b1);
    idle(3);
    #1;
    chk("bub_writes", 32'(wr_total), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bub_order", (addr_log.size() > i) ? 32'(addr_log[i]) : 32'hFFFFFFFF, 32'(i));
      chk("bub_once", 32'(wcnt[i]), 32'd1);
    end
    chk("bub_mem2", sim_mem[2], 32'hA0000002);
    chk("bub_done", 32'(done), 32'd1);

    // full-depth program
    clr_log();
    pulse_start();
    for (int i = 0; i < 8; i++) beat(32'h10000000 + 32'(i), i == 7);
    idle(3);
    #1;
    chk("full_done", 32'(done), 32'd1);
    chk("full_ovf", 32'(overflow), 32'd0);
    chk("full_wc", 32'(word_count), 32'd8);
    chk("full_writes", 32'(wr_total), 32'd8);
    chk("full_mem7", sim_mem[7], 32'h10000007);

    // overflow: no in_last on 8th, 9th word must not be taken
    clr_log();
    pulse_start();
    for (int i = 0; i < 8; i++) beat(32'h20000000 + 32'(i), 1'b0);
    @(negedge clk); in_valid = 1'b1; in_data = 32'h20000008; in_last = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_hold", 32'(cpu_hold), 32'd1);
    chk("ovf_done", 32'(done), 32'd0);
    chk("ovf_wc", 32'(word_count), 32'd8);
    chk("ovf_writes", 32'(wr_total), 32'd8);
    chk("ovf_a7", 32'(wcnt[7]), 32'd1);
    chk("ovf_a0", 32'(wcnt[0]), 32'd1);
    chk("ovf_mem0", sim_mem[0], 32'h20000000);
    chk("ovf_mem7", sim_mem[7], 32'h20000007);

    // restart from ERR, reset after 2 of 5 words
    pulse_start();
    #1 chk("err_clear", 32'(overflow), 32'd0);
    beat(32'h30000000, 1'b0);
    beat(32'h30000001, 1'b0);
    #1 chk("pre_rst_we", 32'(imem_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_wc", 32'(word_count), 32'd0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    clr_log();
    pulse_start();
    beat(32'h40000000, 1'b0);
    #1;
    chk("rst_first_we", 32'(imem_we), 32'd1);
    chk("rst_first_addr", 32'(imem_addr), 32'd0);
    beat(32'h40000001, 1'b1);
    idle(3);
    #1;
    chk("rst_end_done", 32'(done), 32'd1);
    chk("rst_end_wc", 32'(word_count), 32'd2);
    chk("rst_end_mem1", sim_mem[1], 32'h40000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the single-cycle MIPS core's instruction memory. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive word addresses of the instruction memory. It holds the core in reset while loading and releases it once the last word has landed. It also flags a program that overflows the memory depth.

## Interface
- DEPTH, 256: instruction memory depth in 32-bit words; power of two, at least 2.
- ADDR_W, 8: word-address width; equals log2(DEPTH).

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a (re)load.
- in_valid  input  1  in_data/in_last are valid.
- in_data  input  32  instruction word.
- in_last  input  1  marks the final word of the program.
- in_ready  output  1  loader accepts a word this cycle.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address of the write (byte address = imem_addr<<2).
- imem_wdata  output  32  write data.
- cpu_hold  output  1  active-high; integration drives the core's reset from it.
- done  output  1  program fully loaded; core running.
- overflow  output  1  sticky; program exceeded DEPTH words.
- word_count  output  ADDR_W+1  words written in the current or last load.

## Operation
- States: IDLE, LOAD, FLUSH, RUN, ERR.
- Reset values: state=IDLE, cpu_hold=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, overflow=0, word_count=0.
- IDLE:
  - cpu_hold=1.
  - start -> LOAD; the write pointer and word_count are cleared.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - On an accepted beat:
    - Register in_data to imem_wdata and the pointer to imem_addr.
    - Pulse imem_we in the next cycle.
    - Increment the pointer and word_count.
  - Accept with in_last=1 -> FLUSH.
  - Accept at pointer DEPTH-1 with in_last=0 -> ERR, with overflow set. That word is still written.
  - Accept at pointer DEPTH-1 with in_last=1 -> FLUSH. This is a normal full-depth program.
  - start is ignored in LOAD.
- FLUSH:
  - One cycle; the final write strobe is asserted in this cycle.
  - Next state is RUN.
- RUN:
  - cpu_hold=0, done=1.
  - start -> LOAD. cpu_hold reasserts and done clears in the same cycle that LOAD is entered.
  - in_valid is ignored.
- ERR:
  - cpu_hold=1, done=0, overflow=1.
  - start -> LOAD and clears overflow.
- Pointer arithmetic is ADDR_W bits. word_count is ADDR_W+1 bits, so a full load reads DEPTH with no wrap.
- imem_we is registered and never asserted for more than one cycle per accepted beat.
- Reset mid-LOAD:
  - Returns to IDLE immediately and asynchronously.
  - imem_we deasserts immediately; any pending write is dropped.
  - cpu_hold=1.

## Timing
- in_ready is decoded from the state register only, with no combinational path from in_valid.
- Accept at edge T -> imem_we=1 with addr/data during cycle T..T+1, i.e. one-cycle write latency.
- Back-to-back beats: one word per cycle, with imem_we continuously high.
- Last beat accepted at edge T:
  - in_ready=0 from T onward.
  - FLUSH during T..T+1.
  - cpu_hold=0 and done=1 from edge T+1, after the final write is committed at edge T+1.
- start to in_ready: one cycle (start sampled at edge S, in_ready=1 after S).
- start and in_valid in the same IDLE cycle: only start is acted on; no beat is accepted.

## Structure
- Shared package/header holds:
  - the state encoding constants (IDLE=0, LOAD=1, FLUSH=2, RUN=3, ERR=4, 3 bits);
  - the default DEPTH and ADDR_W values, shared with the instruction memory so that the depths agree.
- Single module; no sub-module is warranted. The pointer/counter lives inline with the FSM.
- Integration:
  - imem_* drive the instruction memory's write port.
  - cpu_hold gates the core reset.

## Test plan
- Reset value check: assert rst=0 mid-stream, then release -> all outputs at their reset values, state IDLE, no imem_we.
- Basic 4-word load: start, then send 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 (last on the 4th) back-to-back:
  - imem_we high for exactly 4 consecutive cycles at addresses 0..3 with matching data;
  - cpu_hold falls and done rises 1 cycle after the last accept;
  - word_count=4.
- Backpressure-free bubbles: in_valid toggled 1,0,0,1,1 over a 3-word program -> writes land only at addresses 0,1,2, in order, with no duplicates.
- Full depth, DEPTH=8:
  - 8 words with in_last on the 8th -> done=1, overflow=0, word_count=8.
  - 9th word stream without in_last -> overflow=1, cpu_hold stays 1, address 7 written, address 0 not rewritten.
- Reload from RUN: a start pulse while done=1 -> cpu_hold=1 and done=0 in the next cycle, writes restart at address 0.
- Reset mid-load after 2 of 5 words -> imem_we=0 immediately; on restart, the first write goes to address 0.
